// File: rtl/fpu_pkg.sv
// Shared FPU datapath constants and the normaliser result payload.
//   MANT_W        : mantissa width
//   TAG_W         : destination tag width
//   SHAMT_W       : width of a shift amount over MANT_W bits
//   norm_result_t : normalised mantissa, shift applied, zero flag, tag
package fpu_pkg;

  localparam int unsigned MANT_W  = 24;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned SHAMT_W = $clog2(MANT_W);

  typedef struct packed {
    logic [MANT_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               zero;
    logic [TAG_W-1:0]   tag;
  } norm_result_t;

endpackage

// File: rtl/fp_norm_pipe_lzc_enc.sv
// lzc_enc: combinational leading-zero encoder, reusable by the rounding stage.
//   in_data  : operand
//   out_cnt  : number of leading zeros (0 when the operand is all zeros)
//   out_zero : operand is all zeros
module lzc_enc #(
  parameter int unsigned W  = 24,
  parameter int unsigned CW = $clog2(W)
) (
  input  logic [W-1:0]  in_data,
  output logic [CW-1:0] out_cnt,
  output logic          out_zero
);

  logic w_found;

  // Priority search from the MSB down; first set bit fixes the count.
  always_comb begin
    out_cnt = '0;
    w_found = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!w_found && in_data[i]) begin
        out_cnt = CW'(int'(W) - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  assign out_zero = ~|in_data;

endmodule

// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage mantissa normaliser with valid/ready handshake.
//   S1 counts leading zeros and registers operand/shift/zero/tag;
//   S2 barrel-shifts left and registers the result.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready             : input handshake (in_ready is combinational)
//   in_data, in_even, in_tag      : operand, even-shift request, pass-through tag
//   out_valid/out_ready           : output handshake
//   out_data, out_shamt, out_zero, out_tag : registered result
// Build option: NORM_EVEN_MODE_EN enables in_even; otherwise in_even is ignored.
module fp_norm_pipe
  import fpu_pkg::*;
#(
  parameter  int unsigned WIDTH = MANT_W,
  parameter  int unsigned TAGW  = TAG_W,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_even,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag
);

  logic [SHW-1:0]   w_lzc;
  logic             w_zero;
  logic [SHW-1:0]   w_shamt;
  logic             w_in_fire;
  logic             w_s2_load;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [SHW-1:0]   r_s1_shamt;
  logic             r_s1_zero;
  logic [TAGW-1:0]  r_s1_tag;

  logic [WIDTH-1:0] w_stg [SHW+1];

  lzc_enc #(
    .W  (WIDTH),
    .CW (SHW)
  ) u_lzc (
    .in_data  (in_data),
    .out_cnt  (w_lzc),
    .out_zero (w_zero)
  );

`ifdef NORM_EVEN_MODE_EN
  // Even mode rounds the shift down to even so the top two bits are nonzero.
  assign w_shamt = in_even ? {w_lzc[SHW-1:1], 1'b0} : w_lzc;
`else
  logic w_unused_even;
  assign w_unused_even = in_even;
  assign w_shamt       = w_lzc;
`endif

  // Each stage advances when its downstream slot is empty or draining now.
  assign w_s2_load = r_s1_valid && (!out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  // S1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_tag   <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= in_data;
        r_s1_shamt <= w_shamt;
        r_s1_zero  <= w_zero;
        r_s1_tag   <= in_tag;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Log2 barrel shift: stage k shifts by 2^k when shamt bit k is set.
  always_comb begin
    w_stg[0] = r_s1_data;
    for (int k = 0; k < int'(SHW); k++) begin
      w_stg[k+1] = r_s1_shamt[k] ? (w_stg[k] << (2 ** k)) : w_stg[k];
    end
  end

  // S2 / output register; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (w_s2_load) begin
        out_valid <= 1'b1;
        out_data  <= w_stg[SHW];
        out_shamt <= r_s1_shamt;
        out_zero  <= r_s1_zero;
        out_tag   <= r_s1_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Directed self-checking bench for fp_norm_pipe at WIDTH = 24.
module tb_fp_norm_pipe;
  import fpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_even;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [4:0]  out_shamt;
  logic        out_zero;
  logic [4:0]  out_tag;

  int n_cmp;
  int n_fail;

  fp_norm_pipe #(
    .WIDTH (24),
    .TAGW  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_even   (in_even),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push one operand with out_ready=1, wait (bounded) for its result.
  task automatic run_vec(input logic [23:0] d, input logic ev, input logic [4:0] tg,
                         output norm_result_t res, output int lat);
    @(negedge clk);
    in_data  = d;
    in_even  = ev;
    in_tag   = tg;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        res.data  = out_data;
        res.shamt = out_shamt;
        res.zero  = out_zero;
        res.tag   = out_tag;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_even = 1'b0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, out_shamt, out_zero, out_tag} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d z=%b t=%0d want all 0",
               out_valid, out_data, out_shamt, out_zero, out_tag);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_normal;
    norm_result_t r;
    int lat;
    run_vec(24'h000001, 1'b0, 5'd3, r, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL normal_latency: got %0d want 2", lat);
    end
    n_cmp++;
    if (r !== {24'h800000, 5'd23, 1'b0, 5'd3}) begin
      n_fail++;
      $display("FAIL normal_lsb: got d=%h s=%0d z=%b t=%0d want d=800000 s=23 z=0 t=3",
               r.data, r.shamt, r.zero, r.tag);
    end
    run_vec(24'h800000, 1'b0, 5'd4, r, lat);
    n_cmp++;
    if (lat !== 2 || r !== {24'h800000, 5'd0, 1'b0, 5'd4}) begin
      n_fail++;
      $display("FAIL normal_msb: got lat=%0d d=%h s=%0d z=%b t=%0d want lat=2 d=800000 s=0 z=0 t=4",
               lat, r.data, r.shamt, r.zero, r.tag);
    end
  endtask

  task automatic test_zero;
    norm_result_t r;
    int lat;
    for (int m = 0; m < 2; m++) begin
      run_vec(24'h000000, m[0], 5'd9, r, lat);
      n_cmp++;
      if (lat !== 2 || r !== {24'h000000, 5'd0, 1'b1, 5'd9}) begin
        n_fail++;
        $display("FAIL zero_mode%0d: got lat=%0d d=%h s=%0d z=%b t=%0d want lat=2 d=0 s=0 z=1 t=9",
                 m, lat, r.data, r.shamt, r.zero, r.tag);
      end
    end
  endtask

  task automatic test_even_mode;
    norm_result_t r;
    int lat;
    logic [23:0] vd [3];
    logic [23:0] ed [3];
    logic [4:0]  es [3];
    vd[0] = 24'h000001; vd[1] = 24'h200000; vd[2] = 24'h400000;
`ifdef NORM_EVEN_MODE_EN
    ed[0] = 24'h400000; es[0] = 5'd22;
    ed[1] = 24'h800000; es[1] = 5'd2;
    ed[2] = 24'h400000; es[2] = 5'd0;
`else
    ed[0] = 24'h800000; es[0] = 5'd23;
    ed[1] = 24'h800000; es[1] = 5'd2;
    ed[2] = 24'h800000; es[2] = 5'd1;
`endif
    for (int i = 0; i < 3; i++) begin
      run_vec(vd[i], 1'b1, 5'(10 + i), r, lat);
      n_cmp++;
      if (lat !== 2 || r !== {ed[i], es[i], 1'b0, 5'(10 + i)}) begin
        n_fail++;
        $display("FAIL even_%0d: got lat=%0d d=%h s=%0d z=%b t=%0d want d=%h s=%0d z=0 t=%0d",
                 i, lat, r.data, r.shamt, r.zero, r.tag, ed[i], es[i], 10 + i);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] vd [8];
    logic [23:0] ed [8];
    logic [4:0]  es [8];
    vd[0] = 24'h000001; ed[0] = 24'h800000; es[0] = 5'd23;
    vd[1] = 24'h000003; ed[1] = 24'hC00000; es[1] = 5'd22;
    vd[2] = 24'h00F000; ed[2] = 24'hF00000; es[2] = 5'd8;
    vd[3] = 24'h123456; ed[3] = 24'h91A2B0; es[3] = 5'd3;
    vd[4] = 24'hFFFFFF; ed[4] = 24'hFFFFFF; es[4] = 5'd0;
    vd[5] = 24'h000100; ed[5] = 24'h800000; es[5] = 5'd15;
    vd[6] = 24'h0ABCDE; ed[6] = 24'hABCDE0; es[6] = 5'd4;
    vd[7] = 24'h7FFFFF; ed[7] = 24'hFFFFFE; es[7] = 5'd1;
    out_ready = 1'b1;
    in_even   = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 10) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== ed[k-2] || out_shamt !== es[k-2] ||
            out_zero !== 1'b0 || out_tag !== 5'(k - 2)) begin
          n_fail++;
          $display("FAIL stream_%0d: got v=%b d=%h s=%0d z=%b t=%0d want v=1 d=%h s=%0d z=0 t=%0d",
                   k - 2, out_valid, out_data, out_shamt, out_zero, out_tag, ed[k-2], es[k-2], k - 2);
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_idle_%0d: got out_valid=%b want 0", k, out_valid);
        end
      end
      if (k < 8) begin
        in_valid = 1'b1;
        in_data  = vd[k];
        in_tag   = 5'(k);
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_ready_%0d: got in_ready=%b want 1", k, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_even   = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 24'h000010; in_tag = 5'd20;   // A: lzc 19
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept_a: got in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_data = 24'h030000; in_tag = 5'd21;                    // B: lzc 6
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept_b: got in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_data = 24'h000000; in_tag = 5'd22;                    // C: zero
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 24'h800000 ||
          out_shamt !== 5'd19 || out_zero !== 1'b0 || out_tag !== 5'd20) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got rdy=%b v=%b d=%h s=%0d z=%b t=%0d want rdy=0 v=1 d=800000 s=19 z=0 t=20",
                 s, in_ready, out_valid, out_data, out_shamt, out_zero, out_tag);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 24'hC00000 || out_shamt !== 5'd6 || out_tag !== 5'd21) begin
      n_fail++;
      $display("FAIL bp_drain_b: got v=%b d=%h s=%0d t=%0d want v=1 d=c00000 s=6 t=21",
               out_valid, out_data, out_shamt, out_tag);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 24'h000000 || out_shamt !== 5'd0 ||
        out_zero !== 1'b1 || out_tag !== 5'd22) begin
      n_fail++;
      $display("FAIL bp_drain_c: got v=%b d=%h s=%0d z=%b t=%0d want v=1 d=0 s=0 z=1 t=22",
               out_valid, out_data, out_shamt, out_zero, out_tag);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 24'h000001; in_tag = 5'd30;
    @(negedge clk);
    in_data = 24'h000002; in_tag = 5'd31;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fill: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 24'h0 || out_tag !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_immediate: got v=%b rdy=%b d=%h t=%0d want v=0 rdy=1 d=0 t=0",
               out_valid, in_ready, out_data, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale_%0d: got out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

`ifndef NORM_EVEN_MODE_EN
  task automatic test_macro_off;
    norm_result_t r;
    int lat;
    run_vec(24'h000001, 1'b1, 5'd17, r, lat);
    n_cmp++;
    if (lat !== 2 || r !== {24'h800000, 5'd23, 1'b0, 5'd17}) begin
      n_fail++;
      $display("FAIL macro_off: got lat=%0d d=%h s=%0d z=%b t=%0d want d=800000 s=23 z=0 t=17",
               lat, r.data, r.shamt, r.zero, r.tag);
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_normal();
    test_zero();
    test_even_mode();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifndef NORM_EVEN_MODE_EN
    test_macro_off();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
# fp_norm_pipe

Parametrised, two-stage pipelined mantissa normaliser for the FPU datapath. It counts leading zeros and left-shifts the operand until the MSB is set. An optional even-shift mode stops at an even shift amount, which the square-root unit needs. Sits between the FPU add/sub/sqrt result stage and the rounding stage, with a valid/ready handshake so it can absorb rounding-stage stalls without losing operands.

## Interface
- WIDTH, 24 — mantissa width in bits, ≥ 4
- TAGW, 5 — width of the pass-through tag, typically the destination register number
- SHW, derived: $clog2(WIDTH) — width of the shift amount
- clk  input  1  — clock, rising edge
- rst  input  1  — reset, asynchronous, active-high
- in_valid  input  1  — operand offered
- in_ready  output  1  — block accepts the operand this cycle
- in_data  input  WIDTH  — unnormalised mantissa
- in_even  input  1  — 1: shift amount is forced even
- in_tag  input  TAGW  — carried unchanged to the output
- out_valid  output  1  — result available
- out_ready  input  1  — consumer accepts the result
- out_data  output  WIDTH  — normalised mantissa
- out_shamt  output  SHW  — applied left-shift amount
- out_zero  output  1  — in_data was all zeros
- out_tag  output  TAGW  — tag of this result

## Operation
- A transfer occurs on a rising edge where valid && ready are both high; this holds on both sides.
- lzc = number of leading zeros in in_data, in the range 0..WIDTH-1 for nonzero input.
- Normal mode: shamt = lzc, out_data = in_data << lzc, so out_data[WIDTH-1] = 1.
- Even mode: shamt = lzc & ~1, out_data = in_data << shamt, so out_data[WIDTH-1:WIDTH-2] ≠ 0.
- Zero input: out_zero = 1, out_data = 0, out_shamt = 0. This applies in both modes.
- Shifted-in bits are 0. No bits are lost, because shamt ≤ lzc.
- Stage 1 (S1) computes lzc/shamt with a priority encoder and registers data, shamt, zero, tag and valid.
- Stage 2 (S2) performs a log2 barrel shift on the registered data. It registers all outputs.
- Each stage advances when its downstream slot is empty or is being drained in the same cycle:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_load
- Simultaneous accept and drain in one cycle is legal and sustains 1 operand/cycle.
- While out_valid = 1 and out_ready = 0, out_data, out_shamt, out_zero and out_tag hold stable.
- Stall capacity is 2 operands, one in S1 and one in S2. A third is refused: in_ready = 0.

## Timing
- Latency is 2 cycles from the input transfer to out_valid with no stall. Throughput is 1 per cycle.
- in_ready is combinational from out_ready. There is no combinational path from in_* to out_*.
- Reset values: s1_valid = 0, out_valid = 0, out_data = 0, out_shamt = 0, out_zero = 0, out_tag = 0. in_ready reads 1 after reset.
- Reset asserted mid-operation discards both stages immediately. No result is emitted after release.

## Configuration
- NORM_EVEN_MODE_EN defined: in_even is honoured as described above.
- NORM_EVEN_MODE_EN undefined: the in_even port remains but is ignored, and the even-mode logic is not built. Every operand uses normal mode.

## Structure
- A shared package fpu_pkg holds the mantissa width constant, the derived shift width, and a norm_result_t struct with fields data, shamt, zero and tag.
- One sub-module is natural: lzc_enc, a parametrised leading-zero encoder that outputs count and all-zero. It is reusable by the rounding stage.
- The barrel shift stays inline in S2.

## Test plan
All scenarios use WIDTH = 24.
- Normal mode: in_data 0x000001 -> out_data 0x800000, shamt 23, zero 0. In_data 0x800000 -> out_data 0x800000, shamt 0.
- Even mode: in_data 0x000001 -> out_data 0x400000, shamt 22. In_data 0x200000 -> out_data 0x800000, shamt 2. In_data 0x400000 -> shamt 0.
- Zero input, both modes: in_data 0x000000 -> out_zero 1, out_data 0, shamt 0.
- Streaming: 8 back-to-back operands with out_ready held 1 -> results in order 2 cycles later, with tags matching and no bubbles.
- Backpressure: hold out_ready = 0 while offering 3 operands -> 2 accepted and in_ready = 0 on the third. On release, all 3 appear in order with no loss or duplication, and outputs stay stable while stalled.
- Reset: assert rst with both stages full -> out_valid = 0 and in_ready = 1 immediately. No stale result after release.
- Macro off: in_even = 1 with in_data 0x000001 -> shamt 23, out_data 0x800000.
